// File: rtl/xor_rr_sched_if.sv
// Bundle for the xor_rr_sched requester/result handshakes.
// XOR_RR_SCHED_PARITY_EN adds the res_par result bit.
interface xor_rr_sched_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic                          res_valid;
  logic                          res_ready;
  logic [DATA_WIDTH-1:0]         res_y;
  logic [ID_W-1:0]               res_id;
  logic                          busy;
`ifdef XOR_RR_SCHED_PARITY_EN
  logic                          res_par;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_y, res_id, busy, res_par
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_y, res_id, busy, res_par
  );
`else
  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_y, res_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_y, res_id, busy
  );
`endif
endinterface

// File: rtl/xor_rr_sched.sv
// Round-robin scheduler sharing one registered XOR datapath among NUM_REQ requesters.
// Optional XOR_RR_SCHED_PARITY_EN registers the parity of each result as res_par.
module xor_rr_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  xor_rr_sched_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] res_y_q, res_y_d;
  logic [ID_W-1:0]       res_id_q, res_id_d;
  logic [ID_W-1:0]       last_q, last_d;
  logic [ID_W-1:0]       gnt_id;
  logic [ID_W-1:0]       idx;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    ready;
  logic [DATA_WIDTH-1:0] sel_y;
  logic                  found;
  logic                  free;
  logic                  xfer;
`ifdef XOR_RR_SCHED_PARITY_EN
  logic                  res_par_q, res_par_d;
`endif

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = found && (gnt_id == ID_W'(i));
    end
  end

  always_comb begin
    sel_y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_y = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH] ^ bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ready is suppressed while reset is held so nothing looks accepted.
  assign free  = (state_q == EMPTY) || bus.res_ready;
  assign ready = {NUM_REQ{rst_n & free}} & grant;
  assign xfer  = |(bus.req_valid & ready);

  always_comb begin
    state_d  = state_q;
    res_y_d  = res_y_q;
    res_id_d = res_id_q;
    last_d   = last_q;
`ifdef XOR_RR_SCHED_PARITY_EN
    res_par_d = res_par_q;
`endif
    case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL:  if (bus.res_ready && !xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (xfer) begin
      res_y_d  = sel_y;
      res_id_d = gnt_id;
      last_d   = gnt_id;
`ifdef XOR_RR_SCHED_PARITY_EN
      res_par_d = ^sel_y;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      res_y_q  <= '0;
      res_id_q <= '0;
      last_q   <= ID_W'(NUM_REQ - 1);
`ifdef XOR_RR_SCHED_PARITY_EN
      res_par_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      res_y_q  <= res_y_d;
      res_id_q <= res_id_d;
      last_q   <= last_d;
`ifdef XOR_RR_SCHED_PARITY_EN
      res_par_q <= res_par_d;
`endif
    end
  end

  assign bus.req_ready = ready;
  assign bus.res_valid = (state_q == FULL);
  assign bus.res_y     = res_y_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = (state_q == FULL) || (|bus.req_valid);
`ifdef XOR_RR_SCHED_PARITY_EN
  assign bus.res_par   = res_par_q;
`endif
endmodule

// File: tb/tb_xor_rr_sched.sv
// Self-checking bench for xor_rr_sched: directed scenarios plus a random scoreboard run.
module tb_xor_rr_sched;
  logic clk;
  logic rst_n;
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   m_last    = 3;
  bit   m_full    = 0;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] y;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  xor_rr_sched_if #(.DATA_WIDTH(8), .NUM_REQ(4)) bus ();

  xor_rr_sched #(.DATA_WIDTH(8), .NUM_REQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic exp_t pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[i*8 +: 8] = a;
    bus.req_b[i*8 +: 8] = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    m_last = 3;
    m_full = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, 8'hA5, 8'h0F);
    #2;
    total_cnt++; if (bus.res_valid !== 1'b0) $display("[TB] FAIL rst_valid: got %b want 0", bus.res_valid); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 4'b0) $display("[TB] FAIL rst_ready: got %b want 0000", bus.req_ready); else pass_cnt++;
    step();
    rst_n = 1'b1;
    step();
    step();
    total_cnt++; if (bus.res_valid !== 1'b1) $display("[TB] FAIL burst_valid: got %b want 1", bus.res_valid); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.res_valid !== 1'b0) $display("[TB] FAIL midrst_valid: got %b want 0", bus.res_valid); else pass_cnt++;
    total_cnt++; if (bus.res_y !== 8'h00) $display("[TB] FAIL midrst_y: got %h want 00", bus.res_y); else pass_cnt++;
    total_cnt++; if (bus.res_id !== 2'd0) $display("[TB] FAIL midrst_id: got %0d want 0", bus.res_id); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 4'b0) $display("[TB] FAIL midrst_ready: got %b want 0000", bus.req_ready); else pass_cnt++;
    bus.req_valid = '0;
    step();
    rst_n = 1'b1;
    m_last = 3;
    m_full = 0;
    exp_q.delete();
  endtask

  task automatic test_single_op();
    bus.req_valid = 4'b0100;
    bus.res_ready = 1'b1;
    set_op(2, 8'hF0, 8'h3C);
    exp_q.push_back('{id: 2'd2, y: 8'hF0 ^ 8'h3C});
    #2;
    total_cnt++; if (bus.req_ready !== 4'b0100) $display("[TB] FAIL single_ready: got %b want 0100", bus.req_ready); else pass_cnt++;
    step();
    bus.req_valid = '0;
    #2;
    total_cnt++; if (bus.res_valid !== 1'b1) $display("[TB] FAIL single_valid: got %b want 1", bus.res_valid); else pass_cnt++;
    e = pop_exp();
    total_cnt++; if (bus.res_y !== e.y || bus.res_y !== 8'hCC) $display("[TB] FAIL single_y: got %h want %h", bus.res_y, e.y); else pass_cnt++;
    total_cnt++; if (bus.res_id !== e.id) $display("[TB] FAIL single_id: got %0d want %0d", bus.res_id, e.id); else pass_cnt++;
    step();
    total_cnt++; if (bus.res_valid !== 1'b0) $display("[TB] FAIL single_drain: got %b want 0", bus.res_valid); else pass_cnt++;
    m_last = 2;
    m_full = 0;
  endtask

  task automatic test_back_to_back();
    bus.req_valid = 4'b0010;
    bus.res_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      set_op(1, 8'(c * 17), 8'h5A);
      #2;
      total_cnt++; if (bus.req_ready !== 4'b0010) $display("[TB] FAIL b2b_ready[%0d]: got %b want 0010", c, bus.req_ready); else pass_cnt++;
      if (m_full) begin
        e = pop_exp();
        total_cnt++; if (bus.res_valid !== 1'b1 || bus.res_y !== e.y || bus.res_id !== e.id)
          $display("[TB] FAIL b2b_res[%0d]: got v=%b y=%h id=%0d want y=%h id=%0d", c, bus.res_valid, bus.res_y, bus.res_id, e.y, e.id);
        else pass_cnt++;
      end
      exp_q.push_back('{id: 2'd1, y: 8'(c * 17) ^ 8'h5A});
      m_full = 1;
      step();
    end
    bus.req_valid = '0;
    #2;
    e = pop_exp();
    total_cnt++; if (bus.res_y !== e.y || bus.res_id !== e.id) $display("[TB] FAIL b2b_last: got y=%h id=%0d want y=%h id=%0d", bus.res_y, bus.res_id, e.y, e.id); else pass_cnt++;
    step();
    m_last = 1;
    m_full = 0;
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    logic [7:0] a, b;
    do_reset();
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      for (int i = 0; i < 4; i++) set_op(i, (i == seq[c]) ? a : 8'($urandom), (i == seq[c]) ? b : 8'($urandom));
      #2;
      total_cnt++; if (bus.req_ready !== (4'b0001 << seq[c])) $display("[TB] FAIL rr_ready[%0d]: got %b want grant %0d", c, bus.req_ready, seq[c]); else pass_cnt++;
      if (m_full) begin
        e = pop_exp();
        total_cnt++; if (bus.res_y !== e.y || bus.res_id !== e.id)
          $display("[TB] FAIL rr_res[%0d]: got y=%h id=%0d want y=%h id=%0d", c, bus.res_y, bus.res_id, e.y, e.id);
        else pass_cnt++;
      end
      exp_q.push_back('{id: 2'(seq[c]), y: a ^ b});
      m_full = 1;
      step();
    end
    bus.req_valid = '0;
    #2;
    e = pop_exp();
    total_cnt++; if (bus.res_y !== e.y || bus.res_id !== e.id) $display("[TB] FAIL rr_last: got y=%h id=%0d want y=%h id=%0d", bus.res_y, bus.res_id, e.y, e.id); else pass_cnt++;
    step();
    m_last = 0;
    m_full = 0;
  endtask

  task automatic test_backpressure();
    bus.req_valid = 4'b0011;
    bus.res_ready = 1'b1;
    set_op(0, 8'h55, 8'hAA);
    set_op(1, 8'h12, 8'h34);
    #2;
    total_cnt++; if (bus.req_ready !== 4'b0010) $display("[TB] FAIL bp_first: got %b want 0010", bus.req_ready); else pass_cnt++;
    exp_q.push_back('{id: 2'd1, y: 8'h12 ^ 8'h34});
    step();
    bus.res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      total_cnt++; if (bus.req_ready !== 4'b0000) $display("[TB] FAIL bp_ready[%0d]: got %b want 0000", c, bus.req_ready); else pass_cnt++;
      total_cnt++; if (bus.res_valid !== 1'b1 || bus.res_y !== exp_q[0].y || bus.res_id !== exp_q[0].id)
        $display("[TB] FAIL bp_hold[%0d]: got v=%b y=%h id=%0d want y=%h id=%0d", c, bus.res_valid, bus.res_y, bus.res_id, exp_q[0].y, exp_q[0].id);
      else pass_cnt++;
      set_op(1, 8'($urandom), 8'($urandom));
      step();
    end
    bus.res_ready = 1'b1;
    #2;
    total_cnt++; if (bus.req_ready !== 4'b0001) $display("[TB] FAIL bp_drain_ready: got %b want 0001", bus.req_ready); else pass_cnt++;
    e = pop_exp();
    total_cnt++; if (bus.res_y !== e.y || bus.res_id !== e.id) $display("[TB] FAIL bp_drain_res: got y=%h id=%0d want y=%h id=%0d", bus.res_y, bus.res_id, e.y, e.id); else pass_cnt++;
    exp_q.push_back('{id: 2'd0, y: 8'hFF});
    step();
    bus.req_valid = '0;
    #2;
    e = pop_exp();
    total_cnt++; if (bus.res_y !== e.y || bus.res_id !== e.id) $display("[TB] FAIL bp_next_res: got y=%h id=%0d want y=%h id=%0d", bus.res_y, bus.res_id, e.y, e.id); else pass_cnt++;
    step();
    total_cnt++; if (bus.res_valid !== 1'b0) $display("[TB] FAIL bp_empty: got %b want 0", bus.res_valid); else pass_cnt++;
    m_last = 0;
    m_full = 0;
  endtask

  task automatic test_pointer_wrap();
    do_reset();
    bus.req_valid = 4'b1001;
    bus.res_ready = 1'b1;
    set_op(0, 8'h01, 8'hFF);
    set_op(3, 8'h0F, 8'hF0);
    #2;
    total_cnt++; if (bus.req_ready !== 4'b0001) $display("[TB] FAIL wrap_first: got %b want 0001", bus.req_ready); else pass_cnt++;
    exp_q.push_back('{id: 2'd0, y: 8'hFE});
    step();
    #2;
    total_cnt++; if (bus.req_ready !== 4'b1000) $display("[TB] FAIL wrap_second: got %b want 1000", bus.req_ready); else pass_cnt++;
    e = pop_exp();
    total_cnt++; if (bus.res_y !== e.y || bus.res_id !== e.id) $display("[TB] FAIL wrap_res0: got y=%h id=%0d want y=%h id=%0d", bus.res_y, bus.res_id, e.y, e.id); else pass_cnt++;
    exp_q.push_back('{id: 2'd3, y: 8'hFF});
    step();
    bus.req_valid = '0;
    #2;
    e = pop_exp();
    total_cnt++; if (bus.res_y !== e.y || bus.res_id !== e.id) $display("[TB] FAIL wrap_res3: got y=%h id=%0d want y=%h id=%0d", bus.res_y, bus.res_id, e.y, e.id); else pass_cnt++;
    step();
    m_last = 3;
    m_full = 0;
  endtask

`ifdef XOR_RR_SCHED_PARITY_EN
  task automatic test_parity();
    bus.req_valid = 4'b0001;
    bus.res_ready = 1'b1;
    set_op(0, 8'h01, 8'h02);
    step();
    set_op(0, 8'h01, 8'h00);
    #2;
    total_cnt++; if (bus.res_y !== 8'h03 || bus.res_par !== 1'b0) $display("[TB] FAIL par_even: got y=%h p=%b want y=03 p=0", bus.res_y, bus.res_par); else pass_cnt++;
    step();
    bus.req_valid = '0;
    #2;
    total_cnt++; if (bus.res_y !== 8'h01 || bus.res_par !== 1'b1) $display("[TB] FAIL par_odd: got y=%h p=%b want y=01 p=1", bus.res_y, bus.res_par); else pass_cnt++;
    step();
    m_last = 0;
    m_full = 0;
  endtask
`endif

  task automatic test_random();
    logic [3:0] v;
    logic [3:0] exp_rdy;
    bit rr, free, fire;
    int g;
    for (int c = 0; c < 300; c++) begin
      v = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) set_op(i, 8'($urandom), 8'($urandom));
      bus.req_valid = v;
      bus.res_ready = rr;
      #2;
      free = !m_full || rr;
      g = rr_pick(v, m_last);
      fire = free && (g >= 0);
      exp_rdy = fire ? (4'b0001 << g) : 4'b0000;
      total_cnt++; if (bus.req_ready !== exp_rdy) $display("[TB] FAIL rnd_ready[%0d]: got %b want %b", c, bus.req_ready, exp_rdy); else pass_cnt++;
      total_cnt++; if (bus.res_valid !== m_full || bus.busy !== (m_full || (|v)))
        $display("[TB] FAIL rnd_status[%0d]: got v=%b busy=%b want v=%b busy=%b", c, bus.res_valid, bus.busy, m_full, m_full || (|v));
      else pass_cnt++;
      if (m_full && rr) begin
        e = pop_exp();
        total_cnt++; if (bus.res_y !== e.y || bus.res_id !== e.id)
          $display("[TB] FAIL rnd_res[%0d]: got y=%h id=%0d want y=%h id=%0d", c, bus.res_y, bus.res_id, e.y, e.id);
        else pass_cnt++;
      end
      if (fire) begin
        exp_q.push_back('{id: 2'(g), y: bus.req_a[g*8 +: 8] ^ bus.req_b[g*8 +: 8]});
        m_last = g;
      end
      m_full = fire ? 1'b1 : (rr ? 1'b0 : m_full);
      step();
    end
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single_op();
    test_back_to_back();
    test_round_robin();
    test_backpressure();
    test_pointer_wrap();
`ifdef XOR_RR_SCHED_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
